fifo_drain: RTL

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_drain_skid_buf.sv | 80 ++++++++
 rtl/fifo_drain.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Constants shared by the FIFO drain controller and its output buffer.
//   DEF_DATA_W  : default width of FIFO read data and the output stream
//   FIFO_RD_LAT : upstream FIFO read latency, in cycles from accepted read
//                 to valid fifo_rdata
//   BUF_DEPTH   : number of entries in the ordered output buffer
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int FIFO_RD_LAT = 1;
    localparam int BUF_DEPTH   = 2;

    typedef logic [1:0] occ_t;

endpackage : fifo_pkg

// File: rtl/fifo_drain_skid_buf.sv
// -----------------------------------------------------------------------------
// drain_skid_buf
// Two-entry ordered buffer between the upstream FIFO read data and the output
// stream. Entry 0 is always the oldest word and drives the head output.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_push       : write i_push_data behind any existing entry
//   i_push_data  : word to write
//   i_pop        : remove the head entry
//   o_occ        : number of valid entries, 0..2
//   o_head       : oldest entry (meaningful while o_occ != 0)
// -----------------------------------------------------------------------------
module drain_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output occ_t              o_occ,
    output logic [DATA_W-1:0] o_head
);

    logic [DATA_W-1:0] r_mem0;
    logic [DATA_W-1:0] r_mem1;
    occ_t              r_occ;

    logic w_pop;
    logic w_push;

    // Popping an empty buffer or pushing a full one without a simultaneous
    // pop is dropped; the controller never requests either.
    assign w_pop  = i_pop && (r_occ != 2'd0);
    assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    // Occupancy unchanged; the new word lands right behind
                    // whatever becomes the head.
                    if (r_occ == 2'd1) begin
                        r_mem0 <= i_push_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_push_data;
                    end
                end
                2'b01: begin
                    r_mem0 <= r_mem1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_mem0 <= i_push_data;
                    end else begin
                        r_mem1 <= i_push_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem0;

endmodule : drain_skid_buf

// File: rtl/fifo_drain.sv
// -----------------------------------------------------------------------------
// fifo_drain
// Drains an upstream synchronous FIFO (registered read data, one cycle of read
// latency) into a valid/ready output stream at one word per cycle. Reads are
// only issued when the output buffer is guaranteed to have room for the word
// by the time it returns, so the buffer never overflows.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : permits new FIFO reads
//   fifo_empty : upstream FIFO empty flag
//   fifo_rdata : upstream read data, valid the cycle after an accepted read
//   fifo_r_en  : upstream read strobe (never high while fifo_empty is high)
//   m_valid    : output word available
//   m_data     : output word (oldest buffered entry)
//   m_ready    : downstream accepts the word when high with m_valid
//   count      : words delivered downstream, wraps modulo 2^CNT_W
//   busy       : a word is in flight from the FIFO or held in the buffer
// -----------------------------------------------------------------------------
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_r_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  count,
    output logic              busy
);

    logic              r_inflight;
    logic [CNT_W-1:0]  r_count;

    occ_t              w_occ;
    logic [DATA_W-1:0] w_head;
    logic              w_pop;
    logic [2:0]        w_level;

    drain_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (fifo_rdata),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    assign m_valid = (w_occ != 2'd0);
    assign m_data  = w_head;
    assign w_pop   = m_valid && m_ready;

    // Slots already committed after this edge: buffered plus in flight,
    // minus the word leaving this cycle. A new read needs one free slot.
    assign w_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    // rst_n gates the strobe so no read is accepted while held in reset.
    assign fifo_r_en = rst_n && enable && !fifo_empty
                       && (w_level < 3'(BUF_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            // fifo_r_en already excludes fifo_empty, so it marks an
            // accepted read; this also clears the flag once its data lands
            // unless a back-to-back read replaces it.
            r_inflight <= fifo_r_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_pop) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
    assign busy  = r_inflight || m_valid;

`ifndef SYNTHESIS
    a_no_read_when_empty : assert property (
        @(posedge clk) disable iff (!rst_n) fifo_r_en |-> !fifo_empty
    );

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        ({1'b0, w_occ} + {2'b00, r_inflight}) <= 3'(BUF_DEPTH)
    );

    a_hold_under_backpressure : assert property (
        @(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data))
    );
`endif

endmodule : fifo_drain
